// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings and
// counter sizing used by the arbiter and its round-robin picker.
package dmem_arbiter_pkg;

  // Arbiter FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  // Wait counter width; large enough for the maximum timeout of 255 cycles
  localparam int CNT_W = 8;

  // Index width for a given number of requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: starting just after the previous
// winner and wrapping around, returns the first requesting index.
module rr_picker #(
  parameter int N_CORES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] pos;

  // Scan from last_grant+1 upward; the first hit wins and later hits are ignored
  always_comb begin
    grant   = last_grant;
    any_req = 1'b0;
    pos     = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      pos = IDX_W'((int'(last_grant) + k) % N_CORES);
      if (!any_req && req[pos]) begin
        grant   = pos;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among N_CORES cores.
// One transaction at a time: IDLE picks a requester and latches its
// access, BUSY holds the memory request until ready or timeout, DONE
// pulses the winner's ack for exactly one cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          core_load,
  input  logic [N_CORES-1:0]          core_store,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_wdata,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [N_CORES-1:0]          core_ack,
  output logic [N_CORES-1:0]          core_stall,
  output logic                        core_err,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);

  localparam int IDX_W = idx_width(N_CORES);

  logic [1:0]         state_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [N_CORES-1:0] req;
  logic [CNT_W-1:0]   cnt_q;
  logic               timed_out;

  // Stage 1 (BUSY): latched transaction driving the memory port
  logic               vld_p1;
  logic [IDX_W-1:0]   grant_p1;
  logic               we_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  wdata_p1;

  // Stage 2 (DONE): completion result returned to the granted core
  logic               vld_p2;
  logic [DATA_W-1:0]  rdata_p2;
  logic               err_p2;

  assign req       = core_load | core_store;
  assign vld_p1    = (state_q == ARB_BUSY);
  assign vld_p2    = (state_q == ARB_DONE);
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  rr_picker #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick),
    .any_req    (any_req)
  );

  // Control: state sequencing, wait counter, timeout flag and fairness pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDX_W'(N_CORES - 1);
      grant_p1     <= '0;
      cnt_q        <= '0;
      err_p2       <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            grant_p1 <= pick;
            state_q  <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_ready) begin
            last_grant_q <= grant_p1;
            state_q      <= ARB_DONE;
          end else if (timed_out) begin
            err_p2       <= 1'b1;
            last_grant_q <= grant_p1;
            state_q      <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          err_p2  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Datapath: latch the winner's access on grant, capture read data on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      rdata_p2 <= '0;
    end else begin
      if ((state_q == ARB_IDLE) && any_req) begin
        // A simultaneous load+store is treated as a store
        we_p1    <= core_store[pick];
        addr_p1  <= core_addr[pick*ADDR_W +: ADDR_W];
        wdata_p1 <= core_wdata[pick*DATA_W +: DATA_W];
      end
      if (vld_p1) begin
        if (mem_ready) begin
          rdata_p2 <= mem_rdata;
        end else if (timed_out) begin
          rdata_p2 <= '0;
        end
      end
    end
  end

  assign mem_req    = vld_p1;
  assign mem_we     = we_p1;
  assign mem_addr   = addr_p1;
  assign mem_wdata  = wdata_p1;

  assign core_ack   = vld_p2 ? (N_CORES'(1) << grant_p1) : '0;
  assign core_rdata = rdata_p2;
  assign core_err   = vld_p2 & err_p2;
  assign core_stall = req & ~core_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a scoreboard of expected memory
// accesses and expected core acknowledgements.
module tb_dmem_arbiter;

  localparam int N_CORES = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N_CORES-1:0]        core_load;
  logic [N_CORES-1:0]        core_store;
  logic [N_CORES*ADDR_W-1:0] core_addr;
  logic [N_CORES*DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0]         core_rdata;
  logic [N_CORES-1:0]        core_ack;
  logic [N_CORES-1:0]        core_stall;
  logic                      core_err;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_ready;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .N_CORES (N_CORES),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_load  (core_load),
    .core_store (core_store),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ack   (core_ack),
    .core_stall (core_stall),
    .core_err   (core_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    int                core;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              chk_rd;
  } ack_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                delay;   // BUSY cycle in which ready is given; 0 = never
    logic [DATA_W-1:0] rdata;
  } mem_t;

  ack_t ack_q[$];
  mem_t mem_q[$];
  int   ack_cyc[$];
  int   len_q[$];
  mem_t cur;
  logic              first_we;
  logic [ADDR_W-1:0] first_addr;
  logic [DATA_W-1:0] first_wdata;
  int   busy_cnt;
  int   req_len;
  int   cyc;
  int   checks;
  int   failures;
  logic stray;
  int   t0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input int c, input logic st, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    core_addr[c*ADDR_W +: ADDR_W]  = a;
    core_wdata[c*DATA_W +: DATA_W] = d;
    if (st) core_store[c] = 1'b1;
    else    core_load[c]  = 1'b1;
  endtask

  task automatic expect_txn(input int c, input logic st, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input int dly,
                            input logic [DATA_W-1:0] rd, input bit acked);
    mem_t m;
    ack_t k;
    m.we = st; m.addr = a; m.wdata = wd; m.delay = dly; m.rdata = rd;
    mem_q.push_back(m);
    if (acked) begin
      k.core   = c;
      k.rdata  = (dly == 0) ? '0 : rd;
      k.err    = (dly == 0);
      k.chk_rd = !st || (dly == 0);
      ack_q.push_back(k);
    end
  endtask

  // Memory responder: checks each access at its first BUSY cycle and its stability afterwards
  task automatic mem_model();
    if (mem_req) begin
      busy_cnt++;
      if (busy_cnt == 1) begin
        first_we = mem_we; first_addr = mem_addr; first_wdata = mem_wdata;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected_req", 64'(mem_req), 64'd0);
          cur.delay = 1; cur.rdata = '0;
        end else begin
          cur = mem_q.pop_front();
          chk("mem_we", 64'(mem_we), 64'(cur.we));
          chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
          if (cur.we) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end
      end else begin
        chk("mem_we_stable", 64'(mem_we), 64'(first_we));
        chk("mem_addr_stable", 64'(mem_addr), 64'(first_addr));
        chk("mem_wdata_stable", 64'(mem_wdata), 64'(first_wdata));
      end
      mem_ready = (cur.delay != 0) && (busy_cnt == cur.delay);
      mem_rdata = mem_ready ? cur.rdata : 32'hBAD0_BAD0;
    end else begin
      if (busy_cnt != 0) req_len = busy_cnt;
      busy_cnt  = 0;
      mem_ready = stray;
      mem_rdata = 32'h5EED_0000;
    end
  endtask

  task automatic check_outputs();
    logic [N_CORES-1:0] exp_ack;
    ack_t a;
    if (core_ack != '0) begin
      ack_cyc.push_back(cyc);
      len_q.push_back(req_len);
      if (ack_q.size() == 0) begin
        chk("ack_unexpected", 64'(core_ack), 64'd0);
      end else begin
        a = ack_q.pop_front();
        exp_ack = N_CORES'(1) << a.core;
        chk("ack_grant", 64'(core_ack), 64'(exp_ack));
        chk("stall_at_ack", 64'(core_stall), 64'((core_load | core_store) & ~exp_ack));
        chk("ack_err", 64'(core_err), 64'(a.err));
        if (a.chk_rd) chk("ack_rdata", 64'(core_rdata), 64'(a.rdata));
      end
      core_load  = core_load & ~core_ack;
      core_store = core_store & ~core_ack;
    end else begin
      chk("stall", 64'(core_stall), 64'(core_load | core_store));
      chk("err_without_ack", 64'(core_err), 64'd0);
    end
  endtask

  // One clock cycle: entered at posedge+1 with this cycle's inputs already driven
  task automatic run_cycle();
    #1;
    mem_model();
    #1;
    check_outputs();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((ack_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
      run_cycle();
      n++;
    end
    chk(tag, 64'(ack_q.size() + mem_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; busy_cnt = 0; req_len = 0; stray = 1'b0;
    rst = 1'b1;
    core_load = '0; core_store = '0; core_addr = '0; core_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    cur.delay = 1; cur.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_core_ack", 64'(core_ack), 64'd0);
    chk("rst_core_err", 64'(core_err), 64'd0);
    chk("rst_core_rdata", 64'(core_rdata), 64'd0);
    chk("rst_core_stall", 64'(core_stall), 64'd0);
    rst = 1'b0;
    run_cycle();

    // Contention: all four cores store at once, ready always high (also outside BUSY)
    stray = 1'b1;
    ack_cyc.delete(); len_q.delete();
    for (int i = 0; i < N_CORES; i++) begin
      request(i, 1'b1, 32'h100 + 32'(4*i), 32'h10 + 32'(i));
      expect_txn(i, 1'b1, 32'h100 + 32'(4*i), 32'h10 + 32'(i), 1, 32'h0, 1'b1);
    end
    drain("t2_drain", 30);
    for (int i = 1; i < N_CORES; i++)
      chk("t2_ack_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd3);
    stray = 1'b0;
    run_cycle();

    // Single load: core 1, address 0x40, ready in the first BUSY cycle
    ack_cyc.delete(); len_q.delete();
    t0 = cyc;
    request(1, 1'b0, 32'h40, 32'h0);
    expect_txn(1, 1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF, 1'b1);
    drain("t1_drain", 10);
    chk("t1_latency", 64'(ack_cyc[0] - t0), 64'd2);
    chk("t1_req_len", 64'(len_q[0]), 64'd1);
    run_cycle();

    // Round-robin wrap: serve core 2, then cores 0 and 3 together -> 3 first
    request(2, 1'b0, 32'h500, 32'h0);
    expect_txn(2, 1'b0, 32'h500, 32'h0, 1, 32'h2222_0000, 1'b1);
    drain("t3a_drain", 10);
    request(0, 1'b0, 32'h504, 32'h0);
    request(3, 1'b0, 32'h50C, 32'h0);
    expect_txn(3, 1'b0, 32'h50C, 32'h0, 1, 32'h3333_0000, 1'b1);
    expect_txn(0, 1'b0, 32'h504, 32'h0, 1, 32'h0000_1111, 1'b1);
    drain("t3b_drain", 15);
    run_cycle();

    // Wait states: ready in the fifth BUSY cycle, store with both load and store set
    ack_cyc.delete(); len_q.delete();
    t0 = cyc;
    request(0, 1'b1, 32'h200, 32'hCAFE0001);
    core_load[0] = 1'b1;
    expect_txn(0, 1'b1, 32'h200, 32'hCAFE0001, 5, 32'h0, 1'b1);
    drain("t4_drain", 15);
    chk("t4_latency", 64'(ack_cyc[0] - t0), 64'd6);
    chk("t4_req_len", 64'(len_q[0]), 64'd5);
    run_cycle();

    // Timeout on core 2 with core 3 waiting behind it
    ack_cyc.delete(); len_q.delete();
    t0 = cyc;
    request(2, 1'b0, 32'h300, 32'h0);
    request(3, 1'b0, 32'h304, 32'h0);
    expect_txn(2, 1'b0, 32'h300, 32'h0, 0, 32'h0, 1'b1);
    expect_txn(3, 1'b0, 32'h304, 32'h0, 1, 32'h3300_0033, 1'b1);
    drain("t5_drain", 40);
    chk("t5_timeout_latency", 64'(ack_cyc[0] - t0), 64'(TIMEOUT + 1));
    chk("t5_timeout_req_len", 64'(len_q[0]), 64'(TIMEOUT));
    chk("t5_next_grant_spacing", 64'(ack_cyc[1] - ack_cyc[0]), 64'd3);
    run_cycle();

    // Request dropped while BUSY: the ack still pulses
    ack_cyc.delete(); len_q.delete();
    t0 = cyc;
    request(1, 1'b0, 32'h700, 32'h0);
    expect_txn(1, 1'b0, 32'h700, 32'h0, 3, 32'h7777_7777, 1'b1);
    run_cycle();
    run_cycle();
    core_load[1] = 1'b0;
    drain("drop_drain", 10);
    chk("drop_latency", 64'(ack_cyc[0] - t0), 64'd4);
    run_cycle();

    // Reset mid-BUSY: core 2 access abandoned, then core 0 has priority over core 3
    request(2, 1'b0, 32'h800, 32'h0);
    expect_txn(2, 1'b0, 32'h800, 32'h0, 0, 32'h0, 1'b0);
    run_cycle();
    run_cycle();
    run_cycle();
    rst = 1'b1;
    core_load = '0; core_store = '0;
    #1;
    chk("t6_mem_req_in_reset", 64'(mem_req), 64'd0);
    chk("t6_ack_in_reset", 64'(core_ack), 64'd0);
    chk("t6_addr_in_reset", 64'(mem_addr), 64'd0);
    chk("t6_stall_in_reset", 64'(core_stall), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_cnt = 0;
    request(0, 1'b0, 32'h600, 32'h0);
    request(3, 1'b0, 32'h60C, 32'h0);
    expect_txn(0, 1'b0, 32'h600, 32'h0, 1, 32'h0600_0600, 1'b1);
    expect_txn(3, 1'b0, 32'h60C, 32'h0, 1, 32'h060C_060C, 1'b1);
    drain("t6_drain", 15);
    run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
